mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle control unit, the driving end of the ALU control interface (aluop, ALUSrc, sll_slt).
- Sequences each instruction through INIT/FETCH/DECODE/EXEC/MEM/WB states.
- Decodes op/funct from the latched instruction register.
- Produces every datapath enable and mux select for the 10-instruction core: addu, subu, sll, jr, ori, lw, sw, beq, lui, jal.
- Sits between the instruction register and the PC, register file, DM, EXT and ALU.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
ins  in  32  instruction register contents; op=ins[31:26], funct=ins[5:0]
zero  in  1  ALU zero flag
aluop  out  3  0 add, 1 sub, 2 and, 3 or, 4 not, 5 sll
ALUSrc  out  1  ALU B operand: 1 imm_ext, 0 rt_out
sll_slt  out  1  ALU A operand: 1 rt_out, 0 rs_out
ext_op  out  2  0 zero-extend, 1 sign-extend, 2 imm<<16
ir_we  out  1  instruction register load
pc_we  out  1  PC load
npc_sel  out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs_out
reg_we  out  1  register file write
reg_dst  out  2  0 rt, 1 rd, 2 $31
mem_to_reg  out  2  0 ALU result, 1 DM data, 2 PC+4
mem_we  out  1  data memory write
illegal  out  1  unrecognised instruction flag
state  out  3  current state: INIT 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALT 6
instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset: state=INIT, instr_cnt=0. Every output is 0. Reset asserted mid-instruction aborts it at once, with no write enables issued.
- INIT: all enables 0, next FETCH; lasts exactly 1 cycle after reset release.
- FETCH: ir_we=1, pc_we=1, npc_sel=0; next DECODE.
- DECODE: jal, jr and illegal instructions finish here; everything else goes to EXEC.
  - jal (op 000011): pc_we=1, npc_sel=2, reg_we=1, reg_dst=2, mem_to_reg=2; retire; next FETCH.
  - jr (op 0, funct 001000): pc_we=1, npc_sel=3; retire; next FETCH.
  - Illegal op/funct: see Optional Feature.
- EXEC:
  - beq (op 000100): pc_we=zero, npc_sel=1; retire; next FETCH.
  - lw (100011) / sw (101011): next MEM.
  - addu (funct 100001), subu (100011), sll (000000), ori (001101), lui (001111): next WB.
- MEM:
  - sw: mem_we=1; retire; next FETCH.
  - lw: next WB.
- WB: reg_we=1; retire; next FETCH.
  - reg_dst: 1 for R-type, 0 otherwise.
  - mem_to_reg: 1 for lw, 0 otherwise.
- ALU controls are a pure function of ins in every state except INIT, where they are 0. Encoding per instruction:
  - addu: aluop 0, ALUSrc 0, sll_slt 0
  - subu: aluop 1, ALUSrc 0, sll_slt 0
  - sll: aluop 5, ALUSrc 0, sll_slt 1
  - ori: aluop 3, ALUSrc 1, ext_op 0
  - lui: aluop 0, ALUSrc 1, ext_op 2 (rs=$0 yields imm<<16)
  - lw/sw: aluop 0, ALUSrc 1, ext_op 1
  - beq: aluop 1, ALUSrc 0
  - others: all 0
- Outside the cases listed, pc_we, ir_we, reg_we and mem_we are 0.
- Retire: instr_cnt increments by 1 on the edge that leaves the final state of an instruction. It wraps modulo 2^CNT_W. Illegal instructions do not retire.
- Latency in cycles, FETCH to return to FETCH:
  - jal, jr: 2
  - beq: 3
  - R-type, ori, lui, sw: 4
  - lw: 5
- sll with ins=0x00000000 is a legal NOP: 4 cycles, writes $0, retires.
- zero is sampled only in EXEC of beq.

Optional Feature:
MC_ILLEGAL_TRAP_EN
- Defined: illegal instruction in DECODE drives illegal=1 and moves to HALT. HALT holds with all enables 0 and illegal=1 until reset.
- Undefined: illegal instruction returns DECODE to FETCH with no enables. illegal pulses 1 for that DECODE cycle only. Execution continues; HALT is unreachable.

Test Plan:
- Reset held then released, ins=0x00851021 (addu $2,$4,$5) → INIT, F, D, E, WB; in WB reg_we=1, reg_dst=1, mem_to_reg=0, aluop=0; instr_cnt=1 after WB.
- ins=0x8C030008 (lw $3,8($0)) → 5 cycles; EXEC aluop=0, ALUSrc=1, ext_op=1; WB mem_to_reg=1, reg_dst=0; mem_we never 1.
- ins=0x10210003 (beq) with zero=1 → EXEC pc_we=1, npc_sel=1; repeat with zero=0 → pc_we=0; both 3 cycles, both retire.
- ins=0x0C000010 (jal) → DECODE pc_we=1, npc_sel=2, reg_we=1, reg_dst=2, mem_to_reg=2; next state FETCH.
- ins=0xFC000000 (illegal) → with MC_ILLEGAL_TRAP_EN: state=6, illegal=1 held, instr_cnt unchanged; without: 1-cycle illegal pulse, back to FETCH.
- reset asserted during MEM of sw → outputs 0 immediately (async), mem_we never asserted, instr_cnt=0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// ----------------------------------------------------------------------------
// mc_ctrl_if -- control bundle between the multi-cycle controller and the
// datapath (PC, instruction register, register file, DM, EXT, ALU).
//
// Signals:
//   ins        [31:0]  instruction register contents (datapath -> controller)
//   zero               ALU zero flag                  (datapath -> controller)
//   aluop      [2:0]   ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 not, 5 sll
//   ALUSrc             ALU B operand: 1 imm_ext, 0 rt_out
//   sll_slt            ALU A operand: 1 rt_out, 0 rs_out
//   ext_op     [1:0]   0 zero-extend, 1 sign-extend, 2 imm<<16
//   ir_we              instruction register load
//   pc_we              PC load
//   npc_sel    [1:0]   0 PC+4, 1 branch target, 2 jump target, 3 rs_out
//   reg_we             register file write
//   reg_dst    [1:0]   0 rt, 1 rd, 2 $31
//   mem_to_reg [1:0]   0 ALU result, 1 DM data, 2 PC+4
//   mem_we             data memory write
//
// Modports: master = controller side, slave = datapath side.
// ----------------------------------------------------------------------------
interface mc_ctrl_if;
    logic [31:0] ins;
    logic        zero;
    logic [2:0]  aluop;
    logic        ALUSrc;
    logic        sll_slt;
    logic [1:0]  ext_op;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  npc_sel;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        mem_we;

    modport master (
        input  ins, zero,
        output aluop, ALUSrc, sll_slt, ext_op,
        output ir_we, pc_we, npc_sel, reg_we, reg_dst, mem_to_reg, mem_we
    );

    modport slave (
        output ins, zero,
        input  aluop, ALUSrc, sll_slt, ext_op,
        input  ir_we, pc_we, npc_sel, reg_we, reg_dst, mem_to_reg, mem_we
    );
endinterface

// File: rtl/mc_ctrl.sv
// ----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle control unit for a 10-instruction MIPS subset
// (addu, subu, sll, jr, ori, lw, sw, beq, lui, jal).
//
// Each instruction walks INIT -> FETCH -> DECODE -> EXEC -> MEM -> WB, leaving
// early once it has nothing more to do. Every datapath enable and mux select
// is a combinational function of the current state and the decoded
// instruction register, so an asynchronous reset zeroes them immediately.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   ctl        ---  mc_ctrl_if.master: ins/zero in, datapath controls out
//   illegal    out  unrecognised instruction flag
//   state      out  current state: INIT 0, FETCH 1, DECODE 2, EXEC 3,
//                   MEM 4, WB 5, HALT 6
//   instr_cnt  out  retired-instruction count (wraps modulo 2^CNT_W)
//
// Parameter:
//   CNT_W      width of the retired-instruction counter
//
// Build option:
//   MC_ILLEGAL_TRAP_EN  when defined, an illegal instruction in DECODE parks
//                       the unit in HALT (illegal held high) until reset.
//                       When undefined, illegal pulses for the DECODE cycle
//                       and the unit returns to FETCH.
// ----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_ctrl_if.master        ctl,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             retire;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [5:0] op;
    logic [5:0] funct;
    logic       is_rtype, is_addu, is_subu, is_sll, is_jr;
    logic       is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;
    logic       is_legal;

    assign op       = ctl.ins[31:26];
    assign funct    = ctl.ins[5:0];
    assign is_rtype = (op == OP_RTYPE);
    assign is_addu  = is_rtype && (funct == FN_ADDU);
    assign is_subu  = is_rtype && (funct == FN_SUBU);
    assign is_sll   = is_rtype && (funct == FN_SLL);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_ori   = (op == OP_ORI);
    assign is_lui   = (op == OP_LUI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_jal   = (op == OP_JAL);
    assign is_legal = is_addu | is_subu | is_sll | is_jr | is_ori |
                      is_lui  | is_lw   | is_sw  | is_beq | is_jal;

    // ALU/EXT controls depend only on the instruction; the state merely
    // forces them to 0 in INIT.
    logic [2:0] alu_op_dec;
    logic       alu_src_dec;
    logic       sll_slt_dec;
    logic [1:0] ext_op_dec;

    always_comb begin
        alu_op_dec  = 3'd0;
        alu_src_dec = 1'b0;
        sll_slt_dec = 1'b0;
        ext_op_dec  = 2'd0;
        if (is_subu || is_beq) begin
            alu_op_dec = 3'd1;
        end else if (is_sll) begin
            alu_op_dec  = 3'd5;
            sll_slt_dec = 1'b1;
        end else if (is_ori) begin
            alu_op_dec  = 3'd3;
            alu_src_dec = 1'b1;
        end else if (is_lui) begin
            // rs is $0 for lui, so add leaves imm<<16 as the result
            alu_src_dec = 1'b1;
            ext_op_dec  = 2'd2;
        end else if (is_lw || is_sw) begin
            alu_src_dec = 1'b1;
            ext_op_dec  = 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; retire marks the final state of an instruction
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        case (state_reg)
            S_INIT:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (is_jal || is_jr) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if (!is_legal) begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_next = S_HALT;
`else
                    state_next = S_FETCH;
`endif
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT:   state_next = S_HALT;
`endif
            // unreachable encodings recover through INIT
            default:  state_next = S_INIT;
        endcase
    end

    assign cnt_next = retire ? (cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_reg;

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        ctl.aluop      = 3'd0;
        ctl.ALUSrc     = 1'b0;
        ctl.sll_slt    = 1'b0;
        ctl.ext_op     = 2'd0;
        ctl.ir_we      = 1'b0;
        ctl.pc_we      = 1'b0;
        ctl.npc_sel    = 2'd0;
        ctl.reg_we     = 1'b0;
        ctl.reg_dst    = 2'd0;
        ctl.mem_to_reg = 2'd0;
        ctl.mem_we     = 1'b0;
        illegal        = 1'b0;

        if (state_reg != S_INIT) begin
            ctl.aluop   = alu_op_dec;
            ctl.ALUSrc  = alu_src_dec;
            ctl.sll_slt = sll_slt_dec;
            ctl.ext_op  = ext_op_dec;
        end

        case (state_reg)
            S_FETCH: begin
                ctl.ir_we = 1'b1;
                ctl.pc_we = 1'b1;
            end
            S_DECODE: begin
                if (is_jal) begin
                    ctl.pc_we      = 1'b1;
                    ctl.npc_sel    = 2'd2;
                    ctl.reg_we     = 1'b1;
                    ctl.reg_dst    = 2'd2;
                    ctl.mem_to_reg = 2'd2;
                end else if (is_jr) begin
                    ctl.pc_we   = 1'b1;
                    ctl.npc_sel = 2'd3;
                end else if (!is_legal) begin
                    illegal = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    ctl.pc_we   = ctl.zero;
                    ctl.npc_sel = 2'd1;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    ctl.mem_we = 1'b1;
                end
            end
            S_WB: begin
                ctl.reg_we     = 1'b1;
                ctl.reg_dst    = is_rtype ? 2'd1 : 2'd0;
                ctl.mem_to_reg = is_lw ? 2'd1 : 2'd0;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT:  illegal = 1'b1;
`endif
            default: ;
        endcase
    end

    assign state     = state_reg;
    assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
// Directed table of instructions with hand-written ALU codes and latencies,
// randomized instruction stream checked cycle by cycle against a per-
// instruction phase-plan model, plus hand sequences for the illegal
// instruction and a reset that lands in the MEM cycle of a store.
// ----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic        clk;
    logic        reset;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    mc_ctrl_if cif ();

    mc_ctrl #(.CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ctl       (cif.master),
        .illegal   (illegal),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cnt_model = 32'd0;
    int          plan[$];

    typedef enum int {
        K_ADDU, K_SUBU, K_SLL, K_JR, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_JAL, K_ILL
    } kind_t;

    typedef struct {
        logic [31:0] ins;
        logic        zero;
        logic [6:0]  alu;   // {aluop, ALUSrc, sll_slt, ext_op}
        int          lat;
    } vec_t;

    // ---------------- reference model ----------------
    function automatic kind_t classify(input logic [31:0] i);
        logic [5:0] op;
        logic [5:0] fn;
        op = i[31:26];
        fn = i[5:0];
        case (op)
            6'b000000: case (fn)
                6'b100001: return K_ADDU;
                6'b100011: return K_SUBU;
                6'b000000: return K_SLL;
                6'b001000: return K_JR;
                default:   return K_ILL;
            endcase
            6'b001101: return K_ORI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b001111: return K_LUI;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [6:0] alu_ctl(input kind_t k);
        case (k)
            K_SUBU, K_BEQ: return {3'd1, 1'b0, 1'b0, 2'd0};
            K_SLL:         return {3'd5, 1'b0, 1'b1, 2'd0};
            K_ORI:         return {3'd3, 1'b1, 1'b0, 2'd0};
            K_LUI:         return {3'd0, 1'b1, 1'b0, 2'd2};
            K_LW, K_SW:    return {3'd0, 1'b1, 1'b0, 2'd1};
            default:       return 7'd0;
        endcase
    endfunction

    // Sequence of states an instruction visits, starting at FETCH.
    task automatic make_plan(input kind_t k);
        case (k)
            K_JAL, K_JR, K_ILL: plan = {1, 2};
            K_BEQ:              plan = {1, 2, 3};
            K_LW:               plan = {1, 2, 3, 4, 5};
            K_SW:               plan = {1, 2, 3, 4};
            default:            plan = {1, 2, 3, 5};
        endcase
    endtask

    // Expected {state, alu(7), ir_we, pc_we, npc_sel, reg_we, reg_dst,
    // mem_to_reg, mem_we, illegal} for instruction kind k in state st.
    function automatic logic [20:0] exp_vec(input kind_t k, input logic z, input int st);
        logic [6:0] a;
        logic       ir, pc, rw, mw, il;
        logic [1:0] npc, rd, m2r;
        logic       rtype;
        rtype = (k == K_ADDU) || (k == K_SUBU) || (k == K_SLL);
        a   = (st == 0) ? 7'd0 : alu_ctl(k);
        ir  = (st == 1);
        pc  = (st == 1) || (st == 2 && (k == K_JAL || k == K_JR)) || (st == 3 && k == K_BEQ && z);
        npc = (st == 2 && k == K_JAL) ? 2'd2 :
              (st == 2 && k == K_JR)  ? 2'd3 :
              (st == 3 && k == K_BEQ) ? 2'd1 : 2'd0;
        rw  = (st == 5) || (st == 2 && k == K_JAL);
        rd  = (st == 2 && k == K_JAL) ? 2'd2 : (st == 5 && rtype) ? 2'd1 : 2'd0;
        m2r = (st == 2 && k == K_JAL) ? 2'd2 : (st == 5 && k == K_LW) ? 2'd1 : 2'd0;
        mw  = (st == 4 && k == K_SW);
        il  = (st == 2 && k == K_ILL) || (st == 6);
        return {st[2:0], a, ir, pc, npc, rw, rd, m2r, mw, il};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {state, cif.aluop, cif.ALUSrc, cif.sll_slt, cif.ext_op, cif.ir_we, cif.pc_we,
                cif.npc_sel, cif.reg_we, cif.reg_dst, cif.mem_to_reg, cif.mem_we, illegal};
    endfunction

    function automatic logic [31:0] gen(input kind_t k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            K_ADDU: begin r[31:26] = 6'd0; r[5:0] = 6'b100001; end
            K_SUBU: begin r[31:26] = 6'd0; r[5:0] = 6'b100011; end
            K_SLL:  begin r[31:26] = 6'd0; r[5:0] = 6'b000000; end
            K_JR:   begin r[31:26] = 6'd0; r[5:0] = 6'b001000; end
            K_ORI:  r[31:26] = 6'b001101;
            K_LW:   r[31:26] = 6'b100011;
            K_SW:   r[31:26] = 6'b101011;
            K_BEQ:  r[31:26] = 6'b000100;
            K_LUI:  r[31:26] = 6'b001111;
            K_JAL:  r[31:26] = 6'b000011;
            default: begin
                if (r[0]) begin r[31:26] = 6'd0; r[5:0] = 6'b101010; end
                else r[31:26] = 6'b111111;
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT in FETCH. Steps one instruction,
    // comparing every cycle; returns the latency measured on the DUT.
    task automatic run_instr(input logic [31:0] iv, input logic zv,
                             output int lat, output logic [6:0] dec_alu);
        kind_t       k;
        int          cyc;
        logic [20:0] e;
        k = classify(iv);
        make_plan(k);
        cif.ins  = iv;
        cif.zero = zv;
        dec_alu  = 7'd0;
        #1;
        cyc = 0;
        while (cyc < 8) begin
            if (cyc > 0 && state == 3'd1) break;
            e = (cyc < plan.size()) ? exp_vec(k, zv, plan[cyc]) : exp_vec(k, zv, 1);
            check($sformatf("cycle ins=%h cyc=%0d", iv, cyc), {43'd0, dut_vec()}, {43'd0, e});
            if (cyc == 1) dec_alu = {cif.aluop, cif.ALUSrc, cif.sll_slt, cif.ext_op};
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        check($sformatf("latency ins=%h", iv), 64'(lat), 64'(plan.size()));
        if (k != K_ILL) cnt_model = cnt_model + 32'd1;
        check($sformatf("instr_cnt ins=%h", iv), {32'd0, instr_cnt}, {32'd0, cnt_model});
        $display("ins=%h zero=%0b lat=%0d instr_cnt=%0d", iv, zv, lat, instr_cnt);
    endtask

    // Called with reset asserted; releases it and walks INIT into FETCH.
    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("init_outputs", {43'd0, dut_vec()}, 64'd0);
        check("init_cnt", {32'd0, instr_cnt}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("fetch_after_init", {61'd0, state}, 64'd1);
    endtask

    vec_t        tbl[11];
    int          lat;
    logic [6:0]  dalu;
    kind_t       rk;

    initial begin
        tbl[0]  = '{32'h00851021, 1'b0, {3'd0, 1'b0, 1'b0, 2'd0}, 4}; // addu
        tbl[1]  = '{32'h8C030008, 1'b0, {3'd0, 1'b1, 1'b0, 2'd1}, 5}; // lw
        tbl[2]  = '{32'h10210003, 1'b1, {3'd1, 1'b0, 1'b0, 2'd0}, 3}; // beq taken
        tbl[3]  = '{32'h10210003, 1'b0, {3'd1, 1'b0, 1'b0, 2'd0}, 3}; // beq not taken
        tbl[4]  = '{32'h0C000010, 1'b0, {3'd0, 1'b0, 1'b0, 2'd0}, 2}; // jal
        tbl[5]  = '{32'h03E00008, 1'b0, {3'd0, 1'b0, 1'b0, 2'd0}, 2}; // jr $31
        tbl[6]  = '{32'hAC030008, 1'b1, {3'd0, 1'b1, 1'b0, 2'd1}, 4}; // sw
        tbl[7]  = '{32'h00851023, 1'b0, {3'd1, 1'b0, 1'b0, 2'd0}, 4}; // subu
        tbl[8]  = '{32'h00000000, 1'b0, {3'd5, 1'b0, 1'b1, 2'd0}, 4}; // sll nop
        tbl[9]  = '{32'h344200FF, 1'b0, {3'd3, 1'b1, 1'b0, 2'd0}, 4}; // ori
        tbl[10] = '{32'h3C011234, 1'b0, {3'd0, 1'b1, 1'b0, 2'd2}, 4}; // lui

        // reset held: everything 0 even with a non-trivial instruction present
        reset    = 1'b1;
        cif.ins  = 32'h3C011234;
        cif.zero = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {43'd0, dut_vec()}, 64'd0);
        check("reset_cnt", {32'd0, instr_cnt}, 64'd0);
        release_reset();

        // directed table
        for (int i = 0; i < 11; i++) begin
            run_instr(tbl[i].ins, tbl[i].zero, lat, dalu);
            check($sformatf("tbl_alu[%0d]", i), {57'd0, dalu}, {57'd0, tbl[i].alu});
            check($sformatf("tbl_lat[%0d]", i), 64'(lat), 64'(tbl[i].lat));
        end

        // randomized stream
        for (int n = 0; n < 150; n++) begin
`ifdef MC_ILLEGAL_TRAP_EN
            rk = kind_t'($urandom_range(0, 9));
`else
            rk = kind_t'($urandom_range(0, 10));
`endif
            run_instr(gen(rk), 1'($urandom_range(0, 1)), lat, dalu);
        end

        // illegal instruction
`ifdef MC_ILLEGAL_TRAP_EN
        cif.ins  = 32'hFC000000;
        cif.zero = 1'b0;
        #1;
        check("ill_fetch", {43'd0, dut_vec()}, {43'd0, exp_vec(K_ILL, 1'b0, 1)});
        @(posedge clk);
        @(negedge clk);
        check("ill_decode", {43'd0, dut_vec()}, {43'd0, exp_vec(K_ILL, 1'b0, 2)});
        for (int h = 0; h < 4; h++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("halt[%0d]", h), {43'd0, dut_vec()}, {43'd0, exp_vec(K_ILL, 1'b0, 6)});
        end
        check("halt_cnt", {32'd0, instr_cnt}, {32'd0, cnt_model});
        $display("ins=fc000000 trap state=%0d illegal=%0b instr_cnt=%0d", state, illegal, instr_cnt);
        reset = 1'b1;
        cnt_model = 32'd0;
        #1;
        check("halt_reset", {43'd0, dut_vec()}, 64'd0);
        release_reset();
`else
        run_instr(32'hFC000000, 1'b0, lat, dalu);
        check("ill_returns_fetch", {61'd0, state}, 64'd1);
        check("ill_pulse_cleared", {63'd0, illegal}, 64'd0);
`endif

        // reset lands in the MEM cycle of a store
        cif.ins  = 32'hAC030008;
        cif.zero = 1'b0;
        #1;
        check("swr_fetch", {43'd0, dut_vec()}, {43'd0, exp_vec(K_SW, 1'b0, 1)});
        @(posedge clk);
        @(negedge clk);
        check("swr_decode", {43'd0, dut_vec()}, {43'd0, exp_vec(K_SW, 1'b0, 2)});
        @(posedge clk);
        @(negedge clk);
        check("swr_exec", {43'd0, dut_vec()}, {43'd0, exp_vec(K_SW, 1'b0, 3)});
        @(posedge clk);
        #1;
        check("swr_mem", {43'd0, dut_vec()}, {43'd0, exp_vec(K_SW, 1'b0, 4)});
        reset = 1'b1;
        cnt_model = 32'd0;
        #1;
        check("swr_reset_outputs", {43'd0, dut_vec()}, 64'd0);
        check("swr_reset_cnt", {32'd0, instr_cnt}, 64'd0);
        @(negedge clk);
        check("swr_mem_we_low", {63'd0, cif.mem_we}, 64'd0);
        $display("ins=ac030008 reset_in_mem state=%0d mem_we=%0b instr_cnt=%0d", state, cif.mem_we, instr_cnt);
        release_reset();
        run_instr(32'h00851021, 1'b0, lat, dalu);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
